// File: rtl/synch_fifo_ext.sv
// Synchronous FIFO with arbitrary depth, sticky error flags,
// almost-full/empty thresholds and show-ahead or registered read.
module synch_fifo_ext #(
  parameter int FIFO_DEPTH = 128,
  parameter int DW         = 32,
  parameter int AF_THRESH  = FIFO_DEPTH-4,
  parameter int AE_THRESH  = 4,
  parameter bit FWFT       = 1'b1,
  localparam int CW        = $clog2(FIFO_DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          flush,
  input  logic          clr_err,
  input  logic          wr_en,
  input  logic [DW-1:0] data_i,
  input  logic          rd_en,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH-1);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          wr_ok;
  logic          rd_ok;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign wr_ok = wr_en & ~full & ~flush;
  assign rd_ok = rd_en & ~empty & ~flush;

  assign count        = cnt;
  assign full         = (cnt == CW'(FIFO_DEPTH));
  assign empty        = (cnt == '0);
  assign almost_full  = (int'(cnt) >= AF_THRESH);
  assign almost_empty = (int'(cnt) <= AE_THRESH);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= inc(wr_ptr);
      if (rd_ok) rd_ptr <= inc(rd_ptr);
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // flush suppresses the request, so it can raise no error either
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow & ~clr_err)
                 | (wr_en & full & ~flush);
      underflow <= (underflow & ~clr_err)
                 | (rd_en & empty & ~flush);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_i;
  end

  if (FWFT) begin : g_fwft
    assign data_o  = mem[rd_ptr];
    assign valid_o = ~empty;
  end else begin : g_reg
    logic [DW-1:0] dreg;
    logic          vreg;

    always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
        dreg <= '0;
        vreg <= 1'b0;
      end else begin
        vreg <= rd_ok;
        if (rd_ok) dreg <= mem[rd_ptr];
      end
    end

    assign data_o  = dreg;
    assign valid_o = vreg;
  end

endmodule

// File: tb/tb_synch_fifo_ext.sv
// Directed scoreboard bench for synch_fifo_ext: a show-ahead
// instance with tight thresholds and a registered-read instance.
module tb_synch_fifo_ext;

  logic clk;
  logic rst_;

  logic       a_fl, a_ce, a_wr, a_rd;
  logic [7:0] a_di, a_do;
  logic       a_v, a_full, a_empty, a_af, a_ae;
  logic [2:0] a_cnt;
  logic       a_ovf, a_udf;

  logic       b_fl, b_ce, b_wr, b_rd;
  logic [7:0] b_di, b_do;
  logic       b_v, b_full, b_empty, b_af, b_ae;
  logic [2:0] b_cnt;
  logic       b_ovf, b_udf;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         mwp, mrp;
  bit         aovf, audf;
  logic [7:0] bhold;
  bit         bv;

  synch_fifo_ext #(
    .FIFO_DEPTH(5), .DW(8), .AF_THRESH(3),
    .AE_THRESH(1), .FWFT(1'b1)
  ) ua (
    .clk(clk), .rst_(rst_), .flush(a_fl),
    .clr_err(a_ce), .wr_en(a_wr), .data_i(a_di),
    .rd_en(a_rd), .data_o(a_do), .valid_o(a_v),
    .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae),
    .count(a_cnt), .overflow(a_ovf),
    .underflow(a_udf)
  );

  synch_fifo_ext #(
    .FIFO_DEPTH(5), .DW(8), .FWFT(1'b0)
  ) ub (
    .clk(clk), .rst_(rst_), .flush(b_fl),
    .clr_err(b_ce), .wr_en(b_wr), .data_i(b_di),
    .rd_en(b_rd), .data_o(b_do), .valid_o(b_v),
    .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae),
    .count(b_cnt), .overflow(b_ovf),
    .underflow(b_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a();
    int n;
    n = qa.size();
    chk("a_count", a_cnt, n);
    chk("a_full", a_full, n == 5);
    chk("a_empty", a_empty, n == 0);
    chk("a_afull", a_af, n >= 3);
    chk("a_aempty", a_ae, n <= 1);
    chk("a_ovf", a_ovf, aovf);
    chk("a_udf", a_udf, audf);
    chk("a_wrptr", ua.wr_ptr, mwp);
    chk("a_rdptr", ua.rd_ptr, mrp);
  endtask

  task automatic stepa(bit w, bit r, logic [7:0] d,
                       bit f = 0, bit c = 0);
    bit fb, eb;
    a_wr = w; a_rd = r; a_di = d;
    a_fl = f; a_ce = c;
    @(negedge clk);
    chk("a_valid", a_v, qa.size() > 0);
    if (qa.size() > 0) chk("a_data", a_do, qa[0]);
    fb = (qa.size() == 5);
    eb = (qa.size() == 0);
    @(posedge clk);
    #1;
    a_wr = 0; a_rd = 0; a_fl = 0; a_ce = 0;
    if (f) begin
      qa.delete();
      mwp = 0; mrp = 0;
      aovf = aovf & ~c;
      audf = audf & ~c;
    end else begin
      aovf = (aovf & ~c) | (w & fb);
      audf = (audf & ~c) | (r & eb);
      if (r && !eb) begin
        void'(qa.pop_front());
        mrp = (mrp + 1) % 5;
      end
      if (w && !fb) begin
        qa.push_back(d);
        mwp = (mwp + 1) % 5;
      end
    end
    chk_a();
  endtask

  task automatic stepb(bit w, bit r, logic [7:0] d,
                       bit f = 0);
    bit fb, eb;
    b_wr = w; b_rd = r; b_di = d; b_fl = f;
    fb = (qb.size() == 5);
    eb = (qb.size() == 0);
    @(posedge clk);
    #1;
    b_wr = 0; b_rd = 0; b_fl = 0;
    bv = 0;
    if (f) begin
      qb.delete();
    end else begin
      if (r && !eb) begin
        bhold = qb.pop_front();
        bv = 1;
      end
      if (w && !fb) qb.push_back(d);
    end
    chk("b_valid", b_v, bv);
    chk("b_data", b_do, bhold);
    chk("b_count", b_cnt, qb.size());
  endtask

  initial begin
    rst_ = 0;
    {a_fl, a_ce, a_wr, a_rd} = '0;
    {b_fl, b_ce, b_wr, b_rd} = '0;
    a_di = '0; b_di = '0;
    mwp = 0; mrp = 0; aovf = 0; audf = 0;
    bhold = '0; bv = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_a();
    chk("a_valid_rst", a_v, 0);
    chk("b_valid_rst", b_v, 0);
    chk("b_data_rst", b_do, 0);
    @(negedge clk);
    rst_ = 1;
    @(posedge clk);
    #1;

    // fill, overflow, drain in order
    for (int i = 0; i < 5; i++)
      stepa(1, 0, 8'(8'h10 + i));
    stepa(1, 0, 8'h15);
    for (int i = 0; i < 5; i++) stepa(0, 1, 0);
    stepa(0, 0, 0, 0, 1);

    // pointer wrap
    for (int i = 0; i < 3; i++)
      stepa(1, 0, 8'(8'h20 + i));
    for (int i = 0; i < 3; i++) stepa(0, 1, 0);
    for (int i = 0; i < 4; i++)
      stepa(1, 0, 8'(8'h23 + i));
    for (int i = 0; i < 4; i++) stepa(0, 1, 0);
    chk("a_wrap_ptr", ua.rd_ptr, 2);

    // simultaneous write/read at empty and full
    stepa(1, 1, 8'h30);
    for (int i = 0; i < 4; i++)
      stepa(1, 0, 8'(8'h31 + i));
    stepa(1, 1, 8'h35);
    stepa(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) stepa(0, 1, 0);
    stepa(0, 1, 0, 0, 1);
    stepa(0, 0, 0, 0, 1);

    // thresholds and flush
    for (int i = 0; i < 3; i++)
      stepa(1, 0, 8'(8'h40 + i));
    stepa(0, 1, 0);
    stepa(0, 1, 0);
    stepa(1, 0, 8'h43);
    stepa(1, 0, 8'h44);
    stepa(1, 0, 8'h55, 1, 0);
    stepa(0, 0, 0);

    // registered read mode
    stepb(1, 0, 8'hAA);
    stepb(1, 0, 8'hBB);
    stepb(0, 1, 0);
    stepb(0, 1, 0);
    stepb(0, 0, 0);
    stepb(1, 0, 8'hCC);
    stepb(0, 1, 0);
    stepb(1, 1, 8'hDD, 1);
    stepb(0, 0, 0);
    stepb(0, 1, 0);

    // asynchronous reset mid-operation
    stepa(1, 0, 8'h60);
    stepa(1, 0, 8'h61);
    stepb(1, 0, 8'h62);
    stepb(0, 1, 0);
    @(negedge clk);
    #2;
    rst_ = 0;
    #1;
    qa.delete();
    mwp = 0; mrp = 0; aovf = 0; audf = 0;
    qb.delete();
    chk_a();
    chk("a_valid_arst", a_v, 0);
    chk("b_valid_arst", b_v, 0);
    chk("b_data_arst", b_do, 0);
    chk("b_count_arst", b_cnt, 0);
    bhold = '0;
    @(negedge clk);
    rst_ = 1;
    @(posedge clk);
    #1;
    stepa(1, 0, 8'h77);
    chk("a_first_entry", ua.mem[0], 8'h77);
    stepa(0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/synch_fifo_ext.md
SYNCH_FIFO_EXT -- requirements
Module: synch_fifo_ext

Interface
REQ-001 The block SHALL have a single clock and its reset SHALL be asynchronous and active-low; ports are named clk and rst_.
REQ-002 Parameter FIFO_DEPTH, default 128, SHALL set the entry count: any integer >= 2, power of two not required.
REQ-003 Parameter DW, default 32, SHALL set the data width in bits.
REQ-004 Parameter AF_THRESH, default FIFO_DEPTH-4, SHALL set the almost_full level in entries.
REQ-005 Parameter AE_THRESH, default 4, SHALL set the almost_empty level in entries.
REQ-006 Parameter FWFT, default 1, SHALL select the read mode: 1 = show-ahead, 0 = registered read.
REQ-007 CW SHALL be $clog2(FIFO_DEPTH+1) and SHALL be used as the count width.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst_  in  1  asynchronous active-low reset.
REQ-010 flush  in  1  synchronous clear of contents.
REQ-011 clr_err  in  1  synchronous clear of the sticky error flags.
REQ-012 wr_en  in  1  write request.
REQ-013 data_i  in  DW  write data.
REQ-014 rd_en  in  1  read request.
REQ-015 data_o  out  DW  read data.
REQ-016 valid_o  out  1  data_o holds valid read data.
REQ-017 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-018 count  out  CW  current occupancy.
REQ-019 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-020 The block SHALL accept a write when wr_en & ~full, storing data_i at wr_ptr; full SHALL be the value before the clock edge.
REQ-021 The block SHALL accept a read when rd_en & ~empty, advancing rd_ptr; empty SHALL be the value before the clock edge.
REQ-022 wr_ptr and rd_ptr SHALL range 0..FIFO_DEPTH-1 and wrap from FIFO_DEPTH-1 to 0.
REQ-023 count SHALL change by +1 on a write only, by -1 on a read only, and SHALL stay unchanged on a simultaneous write and read.
REQ-024 Flags SHALL derive combinationally from count: full = (count==FIFO_DEPTH); empty = (count==0); almost_full = (count>=AF_THRESH); almost_empty = (count<=AE_THRESH).
REQ-025 On a simultaneous write and read with the FIFO full, the write SHALL be rejected, the read SHALL be accepted, and overflow SHALL set.
REQ-026 On a simultaneous write and read with the FIFO empty, the write SHALL be accepted, the read SHALL be rejected, underflow SHALL set, and count SHALL become 1.
REQ-027 overflow SHALL set on any wr_en & full; underflow SHALL set on any rd_en & empty; both SHALL hold until clr_err or reset.
REQ-028 If clr_err coincides with a new error event, the flag SHALL be 1 after the edge (set wins).
REQ-029 With FWFT=1, data_o SHALL equal mem[rd_ptr] combinationally, valid_o SHALL equal ~empty, and a written word SHALL appear on data_o the cycle after its write edge.
REQ-030 With FWFT=0, data_o SHALL be a register loaded with mem[rd_ptr] on an accepted read, valid_o SHALL be 1 for exactly the cycle after each accepted read, and data_o SHALL hold its value otherwise.
REQ-031 flush SHALL zero the pointers and count, clear valid_o, and SHALL take priority over wr_en and rd_en in the same cycle (no write stored, no error flagged).
REQ-032 flush SHALL NOT alter overflow, underflow, memory contents, or the FWFT=0 data_o register.
REQ-033 Memory SHALL have no reset and SHALL be readable without X-propagation into count or the flags.

Reset
REQ-034 While rst_=0, regardless of clk, rd_ptr, wr_ptr, count, valid_o, overflow and underflow SHALL be 0, and the FWFT=0 data_o register SHALL be 0.
REQ-035 After reset, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-036 Reset asserted mid-operation SHALL discard all contents; the first write after deassertion SHALL land at entry 0.

Verification
REQ-037 Scenario, FIFO_DEPTH=5, DW=8, FWFT=1: write 0x10..0x14 -> full=1, count=5; a 6th write -> overflow=1, count=5; read 5 -> data 0x10..0x14 in order, then empty=1.
REQ-038 Scenario, FIFO_DEPTH=5, wrap: 3 writes, 3 reads, 4 writes, 4 reads -> data in order, pointers wrapped to 2, count=0.
REQ-039 Scenario, FWFT=0: write 0xAA, 0xBB, then rd_en for two cycles -> valid_o high in the two following cycles, data_o 0xAA then 0xBB; data_o then holds 0xBB.
REQ-040 Scenario, simultaneous events: with empty, wr_en=rd_en=1 -> count=1, underflow=1; with full, wr_en=rd_en=1 -> count=FIFO_DEPTH-1, overflow=1; clr_err -> both flags 0.
REQ-041 Scenario, thresholds, AF_THRESH=3, AE_THRESH=1: fill to 3 -> almost_full=1, almost_empty=0; drain to 1 -> almost_empty=1.
REQ-042 Scenario, flush/reset: flush with wr_en=1 at count=3 -> count=0, empty=1, no error; rst_ low between clock edges -> outputs reach reset values immediately.
